// File: rtl/cambuf_strip_sched_pkg.sv
// Shared definitions for the camera-buffer strip scheduler.
//   - component codes sent to the block reader (Y, U, V)
//   - scheduler FSM state encoding
//   - plane base offsets and half offset, expressed as multiples of the
//     buffer line length (LUMA_LINE_WORDS)
package cambuf_strip_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FILL = 2'd1,
    ST_EMIT      = 2'd2,
    ST_WAIT_REL  = 2'd3
  } state_t;

  localparam logic [1:0] COMP_Y = 2'd0;
  localparam logic [1:0] COMP_U = 2'd1;
  localparam logic [1:0] COMP_V = 2'd2;

  // Each plane occupies 16 lines (two 8-line halves).
  localparam int BASE_Y_LLW = 0;
  localparam int BASE_U_LLW = 16;
  localparam int BASE_V_LLW = 32;
  localparam int HALF_LLW   = 8;

  // Plane base in units of buffer lines; unused code 3 maps to the Y plane.
  function automatic int comp_base_llw(input logic [1:0] comp);
    case (comp)
      COMP_U:  return BASE_U_LLW;
      COMP_V:  return BASE_V_LLW;
      default: return BASE_Y_LLW;
    endcase
  endfunction

endpackage

// File: rtl/cambuf_blk_addr_gen.sv
// Block address generator.
// Registers the buffer word address of row 0 of an 8x8 block:
//   addr = plane_base(comp) + LLW*8*half + col   (wraps at W_ACAMBUF+1 bits)
// Ports:
//   clk, rst   clock, synchronous active-high reset (address clears to 0)
//   i_comp     component code (Y/U/V)
//   i_half     buffer half (0/1)
//   i_col      MCU column
//   o_addr     registered address, one cycle after the inputs
module cambuf_blk_addr_gen
  import cambuf_strip_sched_pkg::*;
#(
  parameter int LLW       = 80,
  parameter int W_ACAMBUF = 11,
  parameter int W_COL     = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_comp,
  input  logic               i_half,
  input  logic [W_COL:0]     i_col,
  output logic [W_ACAMBUF:0] o_addr
);

  localparam int ADDR_W = W_ACAMBUF + 1;
  localparam logic [W_ACAMBUF:0] HALF_OFF = ADDR_W'(HALF_LLW * LLW);

  logic [W_ACAMBUF:0] w_base;
  logic [W_ACAMBUF:0] w_half_off;
  logic [W_ACAMBUF:0] w_col;
  logic [W_ACAMBUF:0] w_sum;
  logic [W_ACAMBUF:0] r_addr;

  always_comb begin
    w_base     = ADDR_W'(comp_base_llw(i_comp) * LLW);
    w_half_off = i_half ? HALF_OFF : '0;
    w_col      = ADDR_W'(i_col);
    w_sum      = w_base + w_half_off + w_col;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else begin
      r_addr <= w_sum;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/cambuf_strip_sched.sv
// Camera buffer strip scheduler.
// Tracks which 8-line half of the ping-pong camera buffer the write side has
// filled, then issues one 8x8 block read command per component (Y,U,V) per
// MCU column for each full half, frees the half when the reader releases it,
// and frames the picture from start to the last strip.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   encoder_active              enables picture start from IDLE
//   cam_pic_start_f             pulse: new picture begins (abort if busy)
//   camfifo_o_f                 pulse: current write half is full
//   PicWidth_i, PicHeight_i     picture size, sampled at picture start
//   blk_valid/blk_ready         command handshake
//   blk_comp, blk_addr, blk_last  command payload
//   strip_rel                   pulse: reader done with current strip
//   pic_start_o, pic_done_o, pic_abort_o  picture framing pulses
//   overflow_err                sticky write-side overrun flag
module cambuf_strip_sched
  import cambuf_strip_sched_pkg::*;
#(
  parameter int LUMA_LINE_WORDS = 80,
  parameter int W_ACAMBUF       = 11,
  parameter int W_PW            = 11,
  parameter int W_PH            = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               encoder_active,
  input  logic               cam_pic_start_f,
  input  logic               camfifo_o_f,
  input  logic [W_PW:0]      PicWidth_i,
  input  logic [W_PH:0]      PicHeight_i,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [1:0]         blk_comp,
  output logic [W_ACAMBUF:0] blk_addr,
  output logic               blk_last,
  input  logic               strip_rel,
  output logic               pic_start_o,
  output logic               pic_done_o,
  output logic               pic_abort_o,
  output logic               overflow_err
);

  localparam logic [W_PW:0] ONE_PW   = (W_PW + 1)'(1);
  localparam logic [W_PW:0] SEVEN_PW = (W_PW + 1)'(7);
  localparam logic [W_PH:0] ONE_PH   = (W_PH + 1)'(1);
  localparam logic [W_PH:0] SEVEN_PH = (W_PH + 1)'(7);

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_full;
  logic          r_wr_half;
  logic          r_rd_half;
  logic [W_PW:0] r_mcu_cols;
  logic [W_PH:0] r_strips;
  logic [W_PW:0] r_col;
  logic [1:0]    r_comp;
  logic [W_PH:0] r_strip_cnt;
  logic          r_overflow;

  logic [W_PW:0] w_col_next;
  logic [1:0]    w_comp_next;
  logic          w_rd_half_next;
  logic [W_PH:0] w_strip_cnt_next;
  logic          w_init;
  logic          w_rel;
  logic          w_last_cmd;
  logic          w_blk_valid;
  logic          w_blk_last;
  logic          w_pic_start;
  logic          w_pic_abort;
  logic          w_pic_done;
  logic [1:0]    w_rel_mask;
  logic [1:0]    w_wr_mask;
  logic [1:0]    w_full_rel;

  assign w_last_cmd = (r_comp == COMP_V) && (r_col == r_mcu_cols - ONE_PW);

  // Next-state and output decode.
  always_comb begin
    w_state_next     = r_state;
    w_col_next       = r_col;
    w_comp_next      = r_comp;
    w_rd_half_next   = r_rd_half;
    w_strip_cnt_next = r_strip_cnt;
    w_init           = 1'b0;
    w_rel            = 1'b0;
    w_blk_valid      = 1'b0;
    w_blk_last       = 1'b0;
    w_pic_start      = 1'b0;
    w_pic_abort      = 1'b0;
    w_pic_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cam_pic_start_f && encoder_active) begin
          w_init       = 1'b1;
          w_pic_start  = 1'b1;
          w_state_next = ST_WAIT_FILL;
        end
      end
      ST_WAIT_FILL: begin
        if (r_full[r_rd_half]) begin
          w_state_next = ST_EMIT;
          w_col_next   = '0;
          w_comp_next  = COMP_Y;
        end
      end
      ST_EMIT: begin
        w_blk_valid = 1'b1;
        w_blk_last  = w_last_cmd;
        if (blk_ready) begin
          if (r_comp == COMP_V) begin
            w_comp_next = COMP_Y;
            w_col_next  = r_col + ONE_PW;
          end else begin
            w_comp_next = r_comp + 2'd1;
          end
          if (w_last_cmd) begin
            w_state_next = ST_WAIT_REL;
          end
        end
      end
      ST_WAIT_REL: begin
        if (strip_rel) begin
          w_rel            = 1'b1;
          w_rd_half_next   = ~r_rd_half;
          w_strip_cnt_next = r_strip_cnt + ONE_PH;
          if (r_strip_cnt == r_strips - ONE_PH) begin
            w_pic_done   = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_WAIT_FILL;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A new picture while busy overrides whatever the current state decided;
    // any in-flight command is dropped without waiting for the handshake.
    if (r_state != ST_IDLE && cam_pic_start_f) begin
      w_init           = 1'b1;
      w_pic_start      = 1'b1;
      w_pic_abort      = 1'b1;
      w_pic_done       = 1'b0;
      w_rel            = 1'b0;
      w_state_next     = ST_WAIT_FILL;
    end

    if (w_init) begin
      w_col_next       = '0;
      w_comp_next      = COMP_Y;
      w_rd_half_next   = 1'b0;
      w_strip_cnt_next = '0;
    end
  end

  // Release is applied before the fill check so a same-cycle release and
  // fill of one half leaves it full without reporting an overrun.
  assign w_rel_mask = w_rel ? (r_rd_half ? 2'b10 : 2'b01) : 2'b00;
  assign w_wr_mask  = r_wr_half ? 2'b10 : 2'b01;
  assign w_full_rel = r_full & ~w_rel_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_comp      <= COMP_Y;
      r_rd_half   <= 1'b0;
      r_strip_cnt <= '0;
      r_mcu_cols  <= '0;
      r_strips    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_comp      <= w_comp_next;
      r_rd_half   <= w_rd_half_next;
      r_strip_cnt <= w_strip_cnt_next;
      if (w_init) begin
        r_mcu_cols <= (PicWidth_i + SEVEN_PW) >> 3;
        r_strips   <= (PicHeight_i + SEVEN_PH) >> 3;
      end
    end
  end

  // Fill flags, write pointer and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= 2'b00;
      r_wr_half  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_init) begin
      r_full     <= 2'b00;
      r_wr_half  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (camfifo_o_f && r_state != ST_IDLE) begin
      if ((w_full_rel & w_wr_mask) != 2'b00) begin
        r_overflow <= 1'b1;
      end
      r_full    <= w_full_rel | w_wr_mask;
      r_wr_half <= ~r_wr_half;
    end else begin
      r_full <= w_full_rel;
    end
  end

  // Address is computed from the next-cycle command fields so the registered
  // result lines up with r_comp/r_col while the command is presented.
  cambuf_blk_addr_gen #(
    .LLW       (LUMA_LINE_WORDS),
    .W_ACAMBUF (W_ACAMBUF),
    .W_COL     (W_PW)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_comp (w_comp_next),
    .i_half (w_rd_half_next),
    .i_col  (w_col_next),
    .o_addr (blk_addr)
  );

  assign blk_valid    = w_blk_valid;
  assign blk_comp     = r_comp;
  assign blk_last     = w_blk_last;
  assign pic_start_o  = w_pic_start;
  assign pic_done_o   = w_pic_done;
  assign pic_abort_o  = w_pic_abort;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_cambuf_strip_sched.sv
// Directed bench for cambuf_strip_sched: picture framing, command order and
// addresses, fill/overrun tracking, abort and reset behaviour.
module tb_cambuf_strip_sched;
  import cambuf_strip_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        encoder_active;
  logic        cam_pic_start_f;
  logic        camfifo_o_f;
  logic [11:0] PicWidth_i;
  logic [11:0] PicHeight_i;
  logic        blk_valid;
  logic        blk_ready;
  logic [1:0]  blk_comp;
  logic [11:0] blk_addr;
  logic        blk_last;
  logic        strip_rel;
  logic        pic_start_o;
  logic        pic_done_o;
  logic        pic_abort_o;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;

  logic [1:0]  q_comp[$];
  logic [11:0] q_addr[$];
  logic        q_last[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  cambuf_strip_sched dut (
    .clk             (clk),
    .rst             (rst),
    .encoder_active  (encoder_active),
    .cam_pic_start_f (cam_pic_start_f),
    .camfifo_o_f     (camfifo_o_f),
    .PicWidth_i      (PicWidth_i),
    .PicHeight_i     (PicHeight_i),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .blk_comp        (blk_comp),
    .blk_addr        (blk_addr),
    .blk_last        (blk_last),
    .strip_rel       (strip_rel),
    .pic_start_o     (pic_start_o),
    .pic_done_o      (pic_done_o),
    .pic_abort_o     (pic_abort_o),
    .overflow_err    (overflow_err)
  );

  // Accepted commands and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (blk_valid && blk_ready) begin
        q_comp.push_back(blk_comp);
        q_addr.push_back(blk_addr);
        q_last.push_back(blk_last);
        $display("cmd %0d comp=%0d addr=%0d last=%0d", q_addr.size() - 1, blk_comp, blk_addr, blk_last);
      end
      if (pic_done_o) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    encoder_active = 1'b1;
    cam_pic_start_f = 1'b0;
    camfifo_o_f = 1'b0;
    strip_rel = 1'b0;
    blk_ready = 1'b0;
    PicWidth_i = '0;
    PicHeight_i = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic start_pic(input int w, input int h);
    PicWidth_i = 12'(w);
    PicHeight_i = 12'(h);
    encoder_active = 1'b1;
    cam_pic_start_f = 1'b1;
    cyc();
    cam_pic_start_f = 1'b0;
  endtask

  task automatic fill();
    camfifo_o_f = 1'b1;
    cyc();
    camfifo_o_f = 1'b0;
  endtask

  task automatic release_strip();
    strip_rel = 1'b1;
    cyc();
    strip_rel = 1'b0;
  endtask

  task automatic wait_cmds(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    do_reset();
    #2;
    obs = {blk_valid, blk_comp, blk_addr, blk_last, pic_start_o, pic_done_o, pic_abort_o};
    checks++;
    if (obs !== 18'd0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h ovf %b want 0", obs, overflow_err);
    end
    checks++;
    if (dut.r_full !== 2'b00 || dut.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: full %b state %0d want 0/IDLE", dut.r_full, dut.r_state);
    end
    $display("test_reset done");
  endtask

  task automatic test_16x16();
    int base;
    int d0;
    bit ok;
    int exp_addr[6] = '{0, 1280, 2560, 1, 1281, 2561};
    int exp_comp[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    base = q_addr.size();
    d0 = done_cnt;
    blk_ready = 1'b1;
    PicWidth_i = 12'd16;
    PicHeight_i = 12'd16;
    cam_pic_start_f = 1'b1;
    #2;
    checks++;
    if (pic_start_o !== 1'b1 || pic_abort_o !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: start %b abort %b want 1/0", pic_start_o, pic_abort_o);
    end
    cyc();
    cam_pic_start_f = 1'b0;
    camfifo_o_f = 1'b1;
    cyc();
    #2;
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: blk_valid %b want 0", blk_valid);
    end
    cyc();
    camfifo_o_f = 1'b0;
    #2;
    checks++;
    if (blk_valid !== 1'b1 || blk_addr !== 12'd0) begin
      errors++;
      $display("FAIL latency_first: valid %b addr %0d want 1/0", blk_valid, blk_addr);
    end
    wait_cmds(base + 6, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL strip0_timeout: got %0d cmds want 6", q_addr.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q_addr[base+i] !== 12'(exp_addr[i]) || q_comp[base+i] !== 2'(exp_comp[i]) || q_last[base+i] !== (i == 5)) begin
          errors++;
          $display("FAIL strip0_cmd%0d: addr %0d comp %0d last %b want %0d %0d %b", i,
                   q_addr[base+i], q_comp[base+i], q_last[base+i], exp_addr[i], exp_comp[i], i == 5);
        end
      end
    end
    strip_rel = 1'b1;
    #2;
    checks++;
    if (pic_done_o !== 1'b0) begin
      errors++;
      $display("FAIL early_done: pic_done_o %b want 0", pic_done_o);
    end
    cyc();
    strip_rel = 1'b0;
    wait_cmds(base + 12, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL strip1_timeout: got %0d cmds want 12", q_addr.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (q_addr[base+6+i] !== 12'(exp_addr[i] + 640) || q_comp[base+6+i] !== 2'(exp_comp[i])) begin
          errors++;
          $display("FAIL strip1_cmd%0d: addr %0d comp %0d want %0d %0d", i,
                   q_addr[base+6+i], q_comp[base+6+i], exp_addr[i] + 640, exp_comp[i]);
        end
      end
    end
    strip_rel = 1'b1;
    #2;
    checks++;
    if (pic_done_o !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: pic_done_o %b want 1", pic_done_o);
    end
    cyc();
    strip_rel = 1'b0;
    cyc();
    checks++;
    if (done_cnt - d0 !== 1 || blk_valid !== 1'b0 || dut.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL done_count: dones %0d valid %b want 1/0 idle", done_cnt - d0, blk_valid);
    end
    $display("test_16x16 done");
  endtask

  task automatic test_wide();
    int base;
    int d0;
    int nlast;
    bit ok;
    do_reset();
    base = q_addr.size();
    d0 = done_cnt;
    blk_ready = 1'b1;
    start_pic(640, 8);
    fill();
    wait_cmds(base + 240, 400, ok);
    repeat (4) cyc();
    checks++;
    if (!ok || q_addr.size() - base !== 240) begin
      errors++;
      $display("FAIL wide_count: got %0d cmds want 240", q_addr.size() - base);
    end else begin
      checks++;
      if (q_addr[base+239] !== 12'd2639 || q_comp[base+239] !== 2'd2 || q_last[base+239] !== 1'b1) begin
        errors++;
        $display("FAIL wide_last: addr %0d comp %0d last %b want 2639 2 1",
                 q_addr[base+239], q_comp[base+239], q_last[base+239]);
      end
      nlast = 0;
      for (int i = 0; i < 240; i++) if (q_last[base+i]) nlast++;
      checks++;
      if (nlast !== 1 || q_addr[base+3] !== 12'd1 || q_addr[base+121] !== 12'd1320) begin
        errors++;
        $display("FAIL wide_body: lasts %0d addr3 %0d addr121 %0d want 1 1 1320",
                 nlast, q_addr[base+3], q_addr[base+121]);
      end
    end
    strip_rel = 1'b1;
    #2;
    checks++;
    if (pic_done_o !== 1'b1) begin
      errors++;
      $display("FAIL wide_done: pic_done_o %b want 1", pic_done_o);
    end
    cyc();
    strip_rel = 1'b0;
    $display("test_wide done");
  endtask

  task automatic test_overflow();
    do_reset();
    blk_ready = 1'b0;
    start_pic(16, 16);
    fill();
    fill();
    #2;
    checks++;
    if (overflow_err !== 1'b0 || dut.r_full !== 2'b11) begin
      errors++;
      $display("FAIL ovf_two_fills: ovf %b full %b want 0 11", overflow_err, dut.r_full);
    end
    fill();
    repeat (3) cyc();
    checks++;
    if (overflow_err !== 1'b1 || dut.r_full !== 2'b11) begin
      errors++;
      $display("FAIL ovf_third_fill: ovf %b full %b want 1 11", overflow_err, dut.r_full);
    end
    cam_pic_start_f = 1'b1;
    #2;
    checks++;
    if (pic_abort_o !== 1'b1 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_restart: abort %b ovf %b want 1 1", pic_abort_o, overflow_err);
    end
    cyc();
    cam_pic_start_f = 1'b0;
    #2;
    checks++;
    if (overflow_err !== 1'b0 || dut.r_full !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: ovf %b full %b want 0 00", overflow_err, dut.r_full);
    end
    $display("test_overflow done");
  endtask

  task automatic test_fill_release_same();
    int base;
    int d0;
    bit ok;
    do_reset();
    base = q_addr.size();
    d0 = done_cnt;
    blk_ready = 1'b1;
    start_pic(8, 24);
    fill();
    fill();
    wait_cmds(base + 3, 40, ok);
    camfifo_o_f = 1'b1;
    strip_rel = 1'b1;
    cyc();
    camfifo_o_f = 1'b0;
    strip_rel = 1'b0;
    #2;
    checks++;
    if (!ok || overflow_err !== 1'b0 || dut.r_full !== 2'b11) begin
      errors++;
      $display("FAIL same_cycle: ok %b ovf %b full %b want 1 0 11", ok, overflow_err, dut.r_full);
    end
    wait_cmds(base + 6, 40, ok);
    release_strip();
    wait_cmds(base + 9, 40, ok);
    checks++;
    if (!ok || q_addr[base+3] !== 12'd640 || q_addr[base+6] !== 12'd0 || q_addr[base+8] !== 12'd2560) begin
      errors++;
      $display("FAIL same_cycle_strips: got %0d cmds, addr3 %0d addr6 %0d addr8 %0d want 640 0 2560",
               q_addr.size() - base, q_addr[base+3], q_addr[base+6], q_addr[base+8]);
    end
    release_strip();
    cyc();
    checks++;
    if (done_cnt - d0 !== 1 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_done: dones %0d ovf %b want 1 0", done_cnt - d0, overflow_err);
    end
    $display("test_fill_release_same done");
  endtask

  task automatic test_abort();
    int base;
    bit ok;
    do_reset();
    base = q_addr.size();
    blk_ready = 1'b1;
    start_pic(16, 16);
    fill();
    fill();
    wait_cmds(base + 6, 40, ok);
    blk_ready = 1'b0;
    release_strip();
    repeat (3) cyc();
    #2;
    checks++;
    if (!ok || blk_valid !== 1'b1 || blk_addr !== 12'd640) begin
      errors++;
      $display("FAIL abort_pre: ok %b valid %b addr %0d want 1 1 640", ok, blk_valid, blk_addr);
    end
    cam_pic_start_f = 1'b1;
    #1;
    checks++;
    if (pic_abort_o !== 1'b1 || pic_start_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse: abort %b start %b want 1 1", pic_abort_o, pic_start_o);
    end
    cyc();
    cam_pic_start_f = 1'b0;
    #2;
    checks++;
    if (blk_valid !== 1'b0 || pic_abort_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: valid %b abort %b want 0 0", blk_valid, pic_abort_o);
    end
    checks++;
    if (dut.r_col !== '0 || dut.r_comp !== 2'd0 || dut.r_strip_cnt !== '0 || dut.r_rd_half !== 1'b0) begin
      errors++;
      $display("FAIL abort_counters: col %0d comp %0d strip %0d rd %b want 0",
               dut.r_col, dut.r_comp, dut.r_strip_cnt, dut.r_rd_half);
    end
    base = q_addr.size();
    blk_ready = 1'b1;
    fill();
    wait_cmds(base + 1, 20, ok);
    checks++;
    if (!ok || q_addr[base] !== 12'd0 || q_comp[base] !== 2'd0) begin
      errors++;
      $display("FAIL abort_restart: ok %b addr %0d comp %0d want 1 0 0", ok, q_addr[base], q_comp[base]);
    end
    $display("test_abort done");
  endtask

  task automatic test_rst_in_emit();
    logic [17:0] obs;
    do_reset();
    blk_ready = 1'b0;
    start_pic(16, 16);
    fill();
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_emit: valid %b want 1", blk_valid);
    end
    cyc();
    rst = 1'b0;
    #2;
    obs = {blk_valid, blk_comp, blk_addr, blk_last, pic_start_o, pic_done_o, pic_abort_o};
    checks++;
    if (obs !== 18'd0 || overflow_err !== 1'b0 || dut.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_emit_outputs: got %h ovf %b state %0d want 0 IDLE", obs, overflow_err, dut.r_state);
    end
    encoder_active = 1'b0;
    cam_pic_start_f = 1'b1;
    #1;
    checks++;
    if (pic_start_o !== 1'b0) begin
      errors++;
      $display("FAIL inactive_start: pic_start_o %b want 0", pic_start_o);
    end
    cyc();
    cam_pic_start_f = 1'b0;
    fill();
    repeat (3) cyc();
    checks++;
    if (dut.r_state !== ST_IDLE || blk_valid !== 1'b0 || dut.r_full !== 2'b00) begin
      errors++;
      $display("FAIL inactive_idle: state %0d valid %b full %b want IDLE 0 00", dut.r_state, blk_valid, dut.r_full);
    end
    encoder_active = 1'b1;
    $display("test_rst_in_emit done");
  endtask

  initial begin
    test_reset();
    test_16x16();
    test_wide();
    test_overflow();
    test_fill_release_same();
    test_abort();
    test_rst_in_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
